tc_array: RTL and testbench

TC_ARRAY -- requirements
Module: tc_array

---
 rtl/tc_pkg.sv | 42 ++++
 rtl/tc_channel.sv | 122 ++++++++++++
 rtl/tc_array.sv | 64 ++++++
 tb/tb_tc_array.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and constants for the timer/counter array.
// Register map offsets, CTRL bit positions, MODE codes, FSM state.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT,
        ST_DONE
    } tc_state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_FREERUN = 2'b10;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PEND    = 4;

    function automatic logic [31:0] pack_ctrl(
        input logic       en,
        input logic [1:0] mode,
        input logic       im,
        input logic       pend
    );
        logic [31:0] r;
        r                            = '0;
        r[CTRL_EN]                   = en;
        r[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
        r[CTRL_IM]                   = im;
        r[CTRL_PEND]                 = pend;
        return r;
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT registers and the
// IDLE/LOAD/COUNT/DONE sequencer that drives PEND.
module tc_channel
    import tc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_preset,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_rd,
    output logic [31:0] preset_rd,
    output logic [31:0] count_rd,
    output logic        irq
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    tc_state_e        state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       mode_eff;
    logic             hw_pend;
    logic             hw_stop;

    // Encoding 11 behaves exactly like one-shot.
    assign mode_eff = (mode_q == MODE_RELOAD || mode_q == MODE_FREERUN)
                    ? mode_q : MODE_ONESHOT;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hw_pend = 1'b0;
        hw_stop = 1'b0;
        if (!en_q) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    count_d = (mode_eff == MODE_FREERUN) ? '0 : preset_q;
                    state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (mode_eff == MODE_FREERUN) begin
                        count_d = count_q + CNT_ONE;
                        hw_pend = &count_q;
                    end else if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    hw_pend = 1'b1;
                    if (mode_eff == MODE_RELOAD) begin
                        state_d = ST_LOAD;
                    end else begin
                        hw_stop = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A software CTRL write overrides the one-shot EN clear;
    // a hardware PEND set beats a same-edge write-1-to-clear.
    always_comb begin
        en_d     = hw_stop ? 1'b0 : en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        if (wr_ctrl) begin
            en_d   = wdata[CTRL_EN];
            mode_d = wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im_d   = wdata[CTRL_IM];
        end
        if (wr_preset) begin
            preset_d = wdata[WIDTH-1:0];
        end
        pend_d = hw_pend | (pend_q & ~(wr_ctrl & wdata[CTRL_PEND]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    assign ctrl_rd   = pack_ctrl(en_q, mode_q, im_q, pend_q);
    assign preset_rd = 32'(preset_q);
    assign count_rd  = 32'(count_q);
    assign irq       = pend_q & im_q;

endmodule

// File: rtl/tc_array.sv
// Array of NUM_CH timer channels behind a small word-addressed
// register window: address decode, read mux and interrupt OR.
module tc_array
    import tc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    logic [3:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] ctrl_rd   [NUM_CH];
    logic [31:0] preset_rd [NUM_CH];
    logic [31:0] count_rd  [NUM_CH];

    assign ch_sel  = addr[5:2];
    assign reg_sel = addr[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = we && (ch_sel == 4'(i));

        tc_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (hit && reg_sel == REG_CTRL),
            .wr_preset (hit && reg_sel == REG_PRESET),
            .wdata     (wdata),
            .ctrl_rd   (ctrl_rd[i]),
            .preset_rd (preset_rd[i]),
            .count_rd  (count_rd[i]),
            .irq       (irq[i])
        );
    end

    // Unpopulated channels fall through and read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 4'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rdata = ctrl_rd[i];
                    REG_PRESET: rdata = preset_rd[i];
                    REG_COUNT:  rdata = count_rd[i];
                    REG_RSVD:   rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_tc_array.sv
// Scoreboard bench for tc_array: expected irq edges and read
// values are queued at stimulus time and consumed on DUT output.
module tb_tc_array;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_edge = 0;
    int          q_irq0[$];
    int          q_irq1[$];
    logic [31:0] q_rd[$];
    logic [1:0]  irq_prev = '0;

    tc_array #(
        .NUM_CH(NUM_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (irq[0] && !irq_prev[0]) begin
            if (q_irq0.size() == 0)
                check("irq0_unexpected", 32'(irq[0]), 32'd0);
            else
                check("irq0_edge", 32'(cyc), 32'(q_irq0.pop_front()));
        end
        if (irq[1] && !irq_prev[1]) begin
            if (q_irq1.size() == 0)
                check("irq1_unexpected", 32'(irq[1]), 32'd0);
            else
                check("irq1_edge", 32'(cyc), 32'(q_irq1.pop_front()));
        end
        irq_prev <= irq;
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we        = 1'b0;
        last_edge = cyc;
    endtask

    task automatic rd(input string tag, input logic [5:0] a,
                      input logic [31:0] e);
        @(negedge clk);
        we   = 1'b0;
        addr = a;
        q_rd.push_back(e);
        #1;
        check(tag, rdata, q_rd.pop_front());
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e;
        int w;
        reset = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        #2;
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_any", 32'(irq_any), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // one-shot, PRESET=5 with junk above WIDTH
        wr(6'h01, 32'h1234_5605);
        rd("preset_mask", 6'h01, 32'h05);
        wr(6'h00, 32'h09);
        e = last_edge;
        q_irq0.push_back(e + 8);
        wait_until(e + 10);
        rd("os_count", 6'h02, 32'd0);
        rd("os_ctrl", 6'h00, 32'h18);
        check("os_irq_any", 32'(irq_any), 32'd1);
        wr(6'h00, 32'h18);
        rd("os_w1c", 6'h00, 32'h08);
        check("os_irq_low", 32'(irq), 32'd0);

        // auto-reload on ch1, PRESET=3 -> period 5
        wr(6'h05, 32'd3);
        wr(6'h04, 32'h0B);
        e = last_edge;
        q_irq1.push_back(e + 6);
        wait_until(e + 7);
        wr(6'h04, 32'h1B);
        rd("ar_w1c_a", 6'h04, 32'h0B);
        check("ar_irq_clr", 32'(irq[1]), 32'd0);
        q_irq1.push_back(e + 11);
        wait_until(e + 12);
        wr(6'h04, 32'h1B);
        rd("ar_w1c_b", 6'h04, 32'h0B);
        q_irq1.push_back(e + 16);
        wait_until(e + 20);
        wr(6'h04, 32'h1B);
        rd("ar_same_edge", 6'h04, 32'h1B);
        check("ar_same_irq", 32'(irq[1]), 32'd1);
        wait_until(e + 22);
        wr(6'h04, 32'h13);
        rd("ar_im_off", 6'h04, 32'h03);
        wait_until(e + 26);
        rd("ar_pend_no_im", 6'h04, 32'h13);
        check("ar_irq_masked", 32'(irq), 32'd0);
        check("ar_any_masked", 32'(irq_any), 32'd0);
        wait_until(e + 27);
        wr(6'h04, 32'h10);
        rd("ar_stop", 6'h04, 32'd0);

        // PRESET 0 and 1 give the same latency
        wr(6'h01, 32'd0);
        wr(6'h00, 32'h09);
        e = last_edge;
        q_irq0.push_back(e + 4);
        wait_until(e + 6);
        rd("p0_ctrl", 6'h00, 32'h18);
        wr(6'h00, 32'h18);
        wr(6'h01, 32'd1);
        wr(6'h00, 32'h09);
        e = last_edge;
        q_irq0.push_back(e + 4);
        wait_until(e + 6);
        rd("p1_ctrl", 6'h00, 32'h18);
        wr(6'h00, 32'h18);

        // out-of-range channels, read-only and reserved words
        wr(6'h14, 32'hFF);
        rd("oor_ch5", 6'h14, 32'd0);
        wr(6'h08, 32'h09);
        rd("oor_ch2", 6'h08, 32'd0);
        rd("oor_ch0", 6'h00, 32'h08);
        rd("oor_ch1", 6'h04, 32'd0);
        wr(6'h02, 32'h55);
        rd("count_ro", 6'h02, 32'd0);
        wr(6'h03, 32'hFFFF_FFFF);
        rd("rsvd", 6'h03, 32'd0);
        check("oor_irq", 32'(irq), 32'd0);

        // free-run with 8-bit counter: wrap sets PEND
        wr(6'h00, 32'h0D);
        e = last_edge;
        q_irq0.push_back(e + 258);
        wait_until(e + 260);
        rd("fr_count", 6'h02, 32'd2);
        wr(6'h00, 32'h10);
        w = last_edge;
        wait_until(w + 3);
        rd("fr_frozen", 6'h02, 32'((w - e - 2) % 256));
        rd("fr_ctrl", 6'h00, 32'd0);

        // reset mid-count with ch1 interrupt pending
        wr(6'h05, 32'd0);
        wr(6'h04, 32'h09);
        q_irq1.push_back(last_edge + 4);
        wr(6'h01, 32'd6);
        wr(6'h00, 32'h09);
        e = last_edge;
        wait_until(e + 6);
        rd("mid_count", 6'h02, 32'd2);
        check("pre_rst_irq", 32'(irq), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rdata", rdata, 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        check("async_irq_any", 32'(irq_any), 32'd0);
        rd("rst_ctrl1", 6'h04, 32'd0);
        rd("rst_preset0", 6'h01, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        w = cyc;
        wait_until(w + 15);
        rd("post_rst_ctrl0", 6'h00, 32'd0);
        rd("post_rst_count0", 6'h02, 32'd0);
        check("post_rst_irq", 32'(irq), 32'd0);

        check("irq0_left", 32'(q_irq0.size()), 32'd0);
        check("irq1_left", 32'(q_irq1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
